viterbi_traceback_stream: RTL

- Parametrised Viterbi survivor-memory and traceback unit, successor to the fixed-depth, fixed-2-bit traceback.
- Sits after the ACS stage and accepts one survivor vector (predecessor state per state) per trellis step into an internal circular memory.
- Runs sliding-window traceback every DEC_LEN steps, plus a flush traceback at end of frame.
- Emits decoded symbols oldest-first as a valid/ready stream.

---
 rtl/viterbi_traceback_stream_if.sv | 39 +++
 rtl/viterbi_traceback_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback_stream_if.sv
// Stream interface for viterbi_traceback_stream.
// Purpose : carries the ACS-side step handshake (survivor vector, best node,
//           flush/terminate markers) and the decoded-symbol output stream.
// Signals : i_acs_valid/o_acs_ready   step handshake (one trellis step)
//           i_bck_prv_st              predecessor state of every state
//           i_sel_node                best-metric state of this step
//           i_flush/i_term            end of frame / terminated trellis
//           o_data/o_valid/i_ready    decoded symbol stream
//           o_last                    final symbol of a flushed frame
//           o_busy                    traceback or emission in progress
// Modports: master drives the i_* side (producer + sink), slave is the decoder.
interface viterbi_traceback_stream_if #(
  parameter int STATE_REG_NUM = 4,
  parameter int BITS_PER_STEP = 2
);
  localparam int NUM_STATES = 2 ** STATE_REG_NUM;

  logic                                       i_acs_valid;
  logic                                       o_acs_ready;
  logic [NUM_STATES-1:0][STATE_REG_NUM-1:0]   i_bck_prv_st;
  logic [STATE_REG_NUM-1:0]                   i_sel_node;
  logic                                       i_flush;
  logic                                       i_term;
  logic [BITS_PER_STEP-1:0]                   o_data;
  logic                                       o_valid;
  logic                                       i_ready;
  logic                                       o_last;
  logic                                       o_busy;

  modport master (
    output i_acs_valid, i_bck_prv_st, i_sel_node, i_flush, i_term, i_ready,
    input  o_acs_ready, o_data, o_valid, o_last, o_busy
  );

  modport slave (
    input  i_acs_valid, i_bck_prv_st, i_sel_node, i_flush, i_term, i_ready,
    output o_acs_ready, o_data, o_valid, o_last, o_busy
  );
endinterface

// File: rtl/viterbi_traceback_stream.sv
// Viterbi survivor memory with sliding-window and end-of-frame traceback.
// Purpose : stores one survivor vector per trellis step in a circular memory
//           of M = TB_DEPTH + DEC_LEN steps. When M steps are undecoded it
//           traces back M steps from the latched best node, discards the
//           newest TB_DEPTH and emits the oldest DEC_LEN steps oldest-first.
//           A flush traces back all undecoded steps and emits every one,
//           marking the final symbol with o_last.
// Ports   : clk  clock
//           rst  synchronous active-low reset
//           bus  viterbi_traceback_stream_if.slave (step input, symbol output)
module viterbi_traceback_stream #(
  parameter int STATE_REG_NUM = 4,
  parameter int BITS_PER_STEP = 2,
  parameter int TB_DEPTH      = 32,
  parameter int DEC_LEN       = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  viterbi_traceback_stream_if.slave        bus
);
  localparam int NUM_STATES = 2 ** STATE_REG_NUM;
  localparam int M          = TB_DEPTH + DEC_LEN;
  localparam int PTR_W      = $clog2(M);
  localparam int CNT_W      = $clog2(M + 1);

  typedef logic [NUM_STATES-1:0][STATE_REG_NUM-1:0] surv_t;
  typedef enum logic [1:0] {FILL = 2'd0, TRACE = 2'd1, EMIT = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          t_q, t_d;          // traceback step counter
  logic [PTR_W-1:0]          e_q, e_d;          // buffer index being emitted
  logic [CNT_W-1:0]          u_q, u_d;          // undecoded steps in memory
  logic [CNT_W-1:0]          n_q, n_d;          // traceback length
  logic [STATE_REG_NUM-1:0]  node_q, node_d;
  logic [STATE_REG_NUM-1:0]  sel_q, sel_d;
  logic                      flush_q, flush_d;
  logic                      ready_q, ready_d;
  logic                      valid_q, valid_d;
  logic                      last_q, last_d;
  logic                      busy_q, busy_d;
  logic [BITS_PER_STEP-1:0]  data_q, data_d;

  surv_t                     mem_q [M];
  logic [BITS_PER_STEP-1:0]  buf_q [M];

  logic                      mem_we_s;
  logic                      buf_we_s;
  logic [PTR_W-1:0]          buf_idx_s;
  logic [PTR_W-1:0]          wr_nxt_s;
  logic [CNT_W-1:0]          u_inc_s;
  logic [STATE_REG_NUM-1:0]  sel_w_s;
  logic [BITS_PER_STEP-1:0]  node_bits_s;
  logic [PTR_W-1:0]          e_m1_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(M - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(0)) ? PTR_W'(M - 1) : p - PTR_W'(1);
  endfunction

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    t_d       = t_q;
    e_d       = e_q;
    u_d       = u_q;
    n_d       = n_q;
    node_d    = node_q;
    sel_d     = sel_q;
    flush_d   = flush_q;
    valid_d   = valid_q;
    last_d    = last_q;
    data_d    = data_q;
    mem_we_s  = 1'b0;
    buf_we_s  = 1'b0;
    buf_idx_s = PTR_W'(0);
    wr_nxt_s  = wr_ptr_q;
    u_inc_s   = u_q;
    sel_w_s   = sel_q;
    node_bits_s = node_q[BITS_PER_STEP-1:0];
    e_m1_s    = e_q - PTR_W'(1);

    case (state_q)
      FILL: begin
        // ready_q is low only in the first cycle after reset; no step is taken then.
        if (ready_q) begin
          if (bus.i_acs_valid) begin
            mem_we_s = 1'b1;
            wr_nxt_s = ptr_inc(wr_ptr_q);
            u_inc_s  = u_q + CNT_W'(1);
            sel_w_s  = bus.i_sel_node;
          end else begin
            mem_we_s = 1'b0;
            wr_nxt_s = wr_ptr_q;
            u_inc_s  = u_q;
            sel_w_s  = sel_q;
          end
          wr_ptr_d = wr_nxt_s;
          u_d      = u_inc_s;
          sel_d    = sel_w_s;
          // Traceback always begins at the most recently written entry.
          rd_ptr_d = ptr_dec(wr_nxt_s);
          t_d      = PTR_W'(0);
          // While ready, i_flush qualifies both with and without a step.
          if (bus.i_flush && (u_inc_s != CNT_W'(0))) begin
            state_d = TRACE;
            n_d     = u_inc_s;
            flush_d = 1'b1;
            node_d  = bus.i_term ? STATE_REG_NUM'(0) : sel_w_s;
          end else if (!bus.i_flush && (u_inc_s == CNT_W'(M))) begin
            state_d = TRACE;
            n_d     = CNT_W'(M);
            flush_d = 1'b0;
            node_d  = sel_w_s;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end

      TRACE: begin
        // Window traces drop the newest TB_DEPTH (unconverged) steps.
        if (flush_q) begin
          buf_we_s  = 1'b1;
          buf_idx_s = t_q;
        end else if (t_q >= PTR_W'(TB_DEPTH)) begin
          buf_we_s  = 1'b1;
          buf_idx_s = t_q - PTR_W'(TB_DEPTH);
        end else begin
          buf_we_s  = 1'b0;
        end
        node_d   = mem_q[rd_ptr_q][node_q];
        rd_ptr_d = ptr_dec(rd_ptr_q);
        t_d      = t_q + PTR_W'(1);
        if (CNT_W'(t_q) == (n_q - CNT_W'(1))) begin
          state_d = EMIT;
          e_d     = flush_q ? PTR_W'(n_q - CNT_W'(1)) : PTR_W'(DEC_LEN - 1);
          valid_d = 1'b1;
          // The step traced last is the oldest and goes out first; bypass the buffer.
          data_d  = node_bits_s;
          last_d  = flush_q && (n_q == CNT_W'(1));
        end else begin
          state_d = TRACE;
        end
      end

      EMIT: begin
        if (valid_q && bus.i_ready) begin
          if (e_q == PTR_W'(0)) begin
            state_d = FILL;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = BITS_PER_STEP'(0);
            if (flush_q) begin
              u_d      = CNT_W'(0);
              wr_ptr_d = PTR_W'(0);
            end else begin
              // Keep the convergence span for the next window.
              u_d      = CNT_W'(TB_DEPTH);
            end
          end else begin
            e_d    = e_m1_s;
            data_d = buf_q[e_m1_s];
            last_d = flush_q && (e_m1_s == PTR_W'(0));
          end
        end else begin
          state_d = EMIT;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    ready_d = (state_d == FILL);
    busy_d  = (state_d != FILL);
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FILL;
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      t_q      <= PTR_W'(0);
      e_q      <= PTR_W'(0);
      u_q      <= CNT_W'(0);
      n_q      <= CNT_W'(0);
      node_q   <= STATE_REG_NUM'(0);
      sel_q    <= STATE_REG_NUM'(0);
      flush_q  <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= BITS_PER_STEP'(0);
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      t_q      <= t_d;
      e_q      <= e_d;
      u_q      <= u_d;
      n_q      <= n_d;
      node_q   <= node_d;
      sel_q    <= sel_d;
      flush_q  <= flush_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      data_q   <= data_d;
    end
  end

  // Survivor memory and reverse buffer; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= bus.i_bck_prv_st;
    end
    if (buf_we_s) begin
      buf_q[buf_idx_s] <= node_bits_s;
    end
  end

  assign bus.o_acs_ready = ready_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_last      = last_q;
  assign bus.o_busy      = busy_q;

endmodule
